// File: rtl/seg_pkg.sv
// Shared segment encodings for the seven-segment encoder/decoder pair.
// Active-low patterns, bit 6 = g down to bit 0 = a.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    TRACK,
    LOCKED
  } state_t;

endpackage

// File: rtl/seg_lookup.sv
// Pattern to digit lookup; hit marks a legal digit,
// is_blank marks the all-off pattern.
import seg_pkg::*;

module seg_lookup (
  input  logic [6:0] pat,
  output logic [2:0] digit,
  output logic       hit,
  output logic       is_blank
);

  always_comb begin
    digit    = 3'd0;
    hit      = 1'b0;
    is_blank = 1'b0;
    unique case (1'b1)
      (pat == SEG_0): begin
        digit = 3'd0;
        hit   = 1'b1;
      end
      (pat == SEG_1): begin
        digit = 3'd1;
        hit   = 1'b1;
      end
      (pat == SEG_2): begin
        digit = 3'd2;
        hit   = 1'b1;
      end
      (pat == SEG_3): begin
        digit = 3'd3;
        hit   = 1'b1;
      end
      (pat == SEG_4): begin
        digit = 3'd4;
        hit   = 1'b1;
      end
      (pat == SEG_5): begin
        digit = 3'd5;
        hit   = 1'b1;
      end
      (pat == SEG_6): begin
        digit = 3'd6;
        hit   = 1'b1;
      end
      (pat == SEG_7): begin
        digit = 3'd7;
        hit   = 1'b1;
      end
      (pat == SEG_BLANK): begin
        is_blank = 1'b1;
      end
      default: begin
        hit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seg_decoder.sv
// Debounced seven-segment receiver: stability filter, settle FSM,
// valid/ready digit register, error flagging and counting.
import seg_pkg::*;

module seg_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       seg_in,
  output logic [2:0]       out_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             blank,
  output logic             overrun
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(STABLE_CYCLES - 1);

  logic [6:0]       seg_q;
  logic [CNT_W-1:0] cnt;
  state_t           state;
  state_t           state_n;
  logic             match;
  logic             settle;
  logic [2:0]       digit;
  logic             hit;
  logic             is_blank;
  logic             bad;

  assign match = (seg_in == seg_q);
  assign bad   = settle && !hit && !is_blank;

  seg_lookup u_lookup (
    .pat      (seg_q),
    .digit    (digit),
    .hit      (hit),
    .is_blank (is_blank)
  );

  always_comb begin
    state_n = state;
    settle  = 1'b0;
    case (state)
      TRACK: begin
        if (match && cnt == CNT_LAST) begin
          settle  = 1'b1;
          state_n = LOCKED;
        end
      end
      LOCKED: begin
        if (!match) state_n = TRACK;
      end
      default: state_n = TRACK;
    endcase
  end

  // cnt saturates at CNT_LAST; only its TRACK value matters
  always_ff @(posedge clk) begin
    if (!reset) begin
      seg_q <= SEG_BLANK;
      cnt   <= '0;
      state <= TRACK;
    end else begin
      seg_q <= seg_in;
      state <= state_n;
      if (!match)
        cnt <= '0;
      else if (cnt != CNT_LAST)
        cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_value <= 3'd0;
      out_valid <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
      blank     <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      err_pulse <= bad;
      if (bad && err_count != '1)
        err_count <= err_count + ERR_W'(1);
      if (settle && is_blank)
        blank <= 1'b1;
      else if (state_n == TRACK)
        blank <= 1'b0;
      if (settle && hit) begin
        out_value <= digit;
        out_valid <= 1'b1;
        if (out_valid && !out_ready)
          overrun <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_decoder.sv
// Scenario bench for seg_decoder: scoreboard of expected digits
// consumed by a handshake monitor, plus per-scenario inline checks.
import seg_pkg::*;

module tb_seg_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] seg_in = SEG_BLANK;
  logic       out_ready = 1'b0;
  logic [2:0] out_value;
  logic       out_valid;
  logic       err_pulse;
  logic [7:0] err_count;
  logic       blank;
  logic       overrun;

  int         errors = 0;
  int         checks = 0;
  int         hs_count = 0;
  bit         mon_en = 1'b1;
  logic [2:0] sb[$];
  logic [6:0] pats[8] = '{SEG_0, SEG_1, SEG_2, SEG_3,
                          SEG_4, SEG_5, SEG_6, SEG_7};

  seg_decoder #(
    .STABLE_CYCLES (4),
    .ERR_W         (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .seg_in    (seg_in),
    .out_value (out_value),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .blank     (blank),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic monitor();
    logic [2:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en && out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow got=%0d required=none",
                   out_value);
        end else begin
          e = sb.pop_front();
          if (out_value !== e) begin
            errors++;
            $display("FAIL sb_value got=%0d required=%0d",
                     out_value, e);
          end
        end
        hs_count++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    seg_in = SEG_BLANK;
    out_ready = 1'b0;
    step(2);
    checks++;
    if (out_value !== 3'd0) begin
      errors++;
      $display("FAIL rst_value got=%0d required=0", out_value);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid got=%b required=0", out_valid);
    end
    checks++;
    if (err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL rst_errp got=%b required=0", err_pulse);
    end
    checks++;
    if (err_count !== 8'd0) begin
      errors++;
      $display("FAIL rst_errc got=%0d required=0", err_count);
    end
    checks++;
    if (blank !== 1'b0) begin
      errors++;
      $display("FAIL rst_blank got=%b required=0", blank);
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL rst_ovr got=%b required=0", overrun);
    end
    reset = 1'b1;
    step(3);
    checks++;
    if (blank !== 1'b0) begin
      errors++;
      $display("FAIL blank_early got=%b required=0", blank);
    end
    step(2);
    checks++;
    if (blank !== 1'b1) begin
      errors++;
      $display("FAIL blank_set got=%b required=1", blank);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL blank_valid got=%b required=0", out_valid);
    end
  endtask

  task automatic test_handshake();
    int h0;
    h0 = hs_count;
    sb.push_back(3'd2);
    seg_in = SEG_2;
    step(4);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hs_early got=%b required=0", out_valid);
    end
    checks++;
    if (blank !== 1'b0) begin
      errors++;
      $display("FAIL blank_clear got=%b required=0", blank);
    end
    step(1);
    checks++;
    if (out_valid !== 1'b1 || out_value !== 3'd2) begin
      errors++;
      $display("FAIL hs_load got=%b/%0d required=1/2",
               out_valid, out_value);
    end
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hs_clear got=%b required=0", out_valid);
    end
    checks++;
    if (hs_count - h0 !== 1) begin
      errors++;
      $display("FAIL hs_count got=%0d required=1", hs_count - h0);
    end
  endtask

  task automatic test_sweep();
    int h0;
    h0 = hs_count;
    out_ready = 1'b1;
    for (int d = 0; d < 8; d++) begin
      sb.push_back(3'(d));
      seg_in = pats[d];
      step(6);
    end
    checks++;
    if (hs_count - h0 !== 8) begin
      errors++;
      $display("FAIL sweep_count got=%0d required=8", hs_count - h0);
    end
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL sweep_left got=%0d required=0", sb.size());
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL sweep_ovr got=%b required=0", overrun);
    end
  endtask

  task automatic test_glitch();
    int h0;
    h0 = hs_count;
    out_ready = 1'b1;
    seg_in = SEG_3;
    step(3);
    sb.push_back(3'd7);
    seg_in = SEG_7;
    step(6);
    checks++;
    if (hs_count - h0 !== 1) begin
      errors++;
      $display("FAIL glitch_one got=%0d required=1", hs_count - h0);
    end
    seg_in = SEG_1;
    step(4);
    checks++;
    if (hs_count - h0 !== 1) begin
      errors++;
      $display("FAIL glitch_short got=%0d required=1", hs_count - h0);
    end
    sb.push_back(3'd7);
    seg_in = SEG_7;
    step(6);
    checks++;
    if (hs_count - h0 !== 2) begin
      errors++;
      $display("FAIL glitch_back got=%0d required=2", hs_count - h0);
    end
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL glitch_left got=%0d required=0", sb.size());
    end
  endtask

  task automatic test_errors();
    int p;
    p = 0;
    out_ready = 1'b0;
    seg_in = 7'b0000000;
    for (int k = 0; k < 6; k++) begin
      step(1);
      if (err_pulse === 1'b1) p++;
    end
    checks++;
    if (p !== 1 || err_count !== 8'd1) begin
      errors++;
      $display("FAIL err_first got=%0d/%0d required=1/1",
               p, err_count);
    end
    for (int i = 0; i < 300; i++) begin
      seg_in = SEG_BLANK;
      for (int k = 0; k < 6; k++) begin
        step(1);
        if (err_pulse === 1'b1) p++;
      end
      if (i == 0) begin
        checks++;
        if (blank !== 1'b1) begin
          errors++;
          $display("FAIL err_blank got=%b required=1", blank);
        end
      end
      seg_in = 7'b0000000;
      for (int k = 0; k < 6; k++) begin
        step(1);
        if (err_pulse === 1'b1) p++;
      end
      if (i == 253) begin
        checks++;
        if (err_count !== 8'd255) begin
          errors++;
          $display("FAIL err_255 got=%0d required=255", err_count);
        end
      end
    end
    checks++;
    if (p !== 301) begin
      errors++;
      $display("FAIL err_pulses got=%0d required=301", p);
    end
    checks++;
    if (err_count !== 8'd255) begin
      errors++;
      $display("FAIL err_sat got=%0d required=255", err_count);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL err_valid got=%b required=0", out_valid);
    end
  endtask

  task automatic test_overrun();
    mon_en = 1'b0;
    sb.delete();
    out_ready = 1'b0;
    seg_in = SEG_5;
    step(6);
    checks++;
    if (out_valid !== 1'b1 || out_value !== 3'd5) begin
      errors++;
      $display("FAIL ovr_d5 got=%b/%0d required=1/5",
               out_valid, out_value);
    end
    seg_in = SEG_1;
    step(4);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_value !== 3'd1
        || overrun !== 1'b0) begin
      errors++;
      $display("FAIL simul got=%b/%0d/%b required=1/1/0",
               out_valid, out_value, overrun);
    end
    seg_in = SEG_6;
    step(6);
    checks++;
    if (out_value !== 3'd6 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_d6 got=%0d/%b required=6/1",
               out_value, overrun);
    end
    seg_in = SEG_3;
    step(2);
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || overrun !== 1'b0
        || err_count !== 8'd0) begin
      errors++;
      $display("FAIL mid_rst got=%b/%b/%0d required=0/0/0",
               out_valid, overrun, err_count);
    end
    step(4);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_early got=%b required=0", out_valid);
    end
    step(1);
    checks++;
    if (out_valid !== 1'b1 || out_value !== 3'd3) begin
      errors++;
      $display("FAIL rst_next got=%b/%0d required=1/3",
               out_valid, out_value);
    end
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_consume got=%b required=0", out_valid);
    end
    mon_en = 1'b1;
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_handshake();
    test_sweep();
    test_glitch();
    test_errors();
    test_overrun();
    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
